// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO and sequences the
// ALU load/persist handshake, returning each result with a one-cycle strobe.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [2:0] in_sel,
    output logic [6:0] out_sel,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
    output logic       err,
    output logic [1:0] state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        HOLD   = 2'b10,
        RETIRE = 2'b11
    } state_e;

    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_e        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [2:0]    cur_op_q, cur_op_d;
    logic [7:0]    num1_q, num1_d;
    logic [7:0]    num2_q, num2_d;
    logic [2:0]    in_sel_q, in_sel_d;
    logic [6:0]    out_sel_q, out_sel_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic [2:0]    res_op_q, res_op_d;
    logic          err_q, err_d;

    logic          push;
    logic          pop;
    logic [18:0]   head;
    logic [2:0]    head_op;

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == IDLE) & on & (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[18:16];

    // FIFO storage write; entries need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Issue sequencer: next state and registered ALU-side outputs
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cur_op_d    = cur_op_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        in_sel_d    = in_sel_q;
        out_sel_d   = out_sel_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                in_sel_d = 3'b000;
                if (pop) begin
                    if (head_op == 3'd7) begin
                        err_d = 1'b1;
                    end else begin
                        num1_d    = head[15:8];
                        num2_d    = head[7:0];
                        out_sel_d = 7'b1000000 >> head_op;
                        cur_op_d  = head_op;
                        in_sel_d  = 3'b010;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                in_sel_d = 3'b100;
                hold_d   = 4'(EXEC_CYCLES - 1);
                state_d  = HOLD;
            end
            HOLD: begin
                if (hold_q == 4'd0) begin
                    res_data_d  = alu_out;
                    res_op_d    = cur_op_q;
                    res_valid_d = 1'b1;
                    in_sel_d    = 3'b000;
                    state_d     = RETIRE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight command and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            cur_op_q    <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            in_sel_q    <= 3'b001;
            out_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            cur_op_q    <= cur_op_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            in_sel_q    <= in_sel_d;
            out_sel_q   <= out_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            err_q       <= err_d;
        end
    end

    assign num1      = num1_q;
    assign num2      = num2_q;
    assign in_sel    = in_sel_q;
    assign out_sel   = out_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule
